// File: rtl/tnoc_pkg.sv
// Shared NoC types: configuration, port types and the flit layout.
`timescale 1ns/1ps
package tnoc_pkg;

    typedef struct packed {
        int virtual_channels;
        int data_width;
    } tnoc_config;

    localparam tnoc_config TNOC_DEFAULT_CONFIG = '{
        virtual_channels: 2,
        data_width:       32
    };

    typedef enum logic {
        TNOC_LOCAL_PORT,
        TNOC_INTERNAL_PORT
    } tnoc_port_type;

    function automatic logic is_local_port(tnoc_port_type port_type);
        return port_type == TNOC_LOCAL_PORT;
    endfunction

    localparam int TNOC_DATA_WIDTH = TNOC_DEFAULT_CONFIG.data_width;

    typedef enum logic [1:0] {
        TNOC_HEADER_FLIT,
        TNOC_PAYLOAD_FLIT,
        TNOC_TAIL_FLIT
    } tnoc_flit_type;

    typedef struct packed {
        tnoc_flit_type              flit_type;
        logic                       head;
        logic                       tail;
        logic [TNOC_DATA_WIDTH-1:0] data;
    } tnoc_flit;

    localparam int TNOC_FLIT_WIDTH = $bits(tnoc_flit);

endpackage

// File: rtl/tnoc_flit_if.sv
// Flit channel with per-VC valid/ready and VC availability.
`timescale 1ns/1ps
interface tnoc_flit_if #(
    parameter tnoc_pkg::tnoc_config    CONFIG    = tnoc_pkg::TNOC_DEFAULT_CONFIG,
    parameter tnoc_pkg::tnoc_port_type PORT_TYPE = tnoc_pkg::TNOC_LOCAL_PORT
);
    import tnoc_pkg::*;

    localparam int CHANNELS = CONFIG.virtual_channels;
    // Internal ports share one flit lane across all VCs.
    localparam int FLITS    = is_local_port(PORT_TYPE) ? CHANNELS : 1;

    logic [CHANNELS-1:0] valid;
    logic [CHANNELS-1:0] ready;
    logic [CHANNELS-1:0] vc_available;
    tnoc_flit            flit [FLITS];

    modport initiator (
        output valid,
        output flit,
        input  ready,
        input  vc_available
    );

    modport target (
        input  valid,
        input  flit,
        output ready,
        output vc_available
    );

endinterface

// File: rtl/tnoc_fifo.sv
// Single-clock FIFO with occupancy count; storage is not reset.
`timescale 1ns/1ps
module tnoc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = count_q == CNT_W'(DEPTH);
    assign empty    = count_q == '0;
    assign count    = count_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && full))
            else $error("tnoc_fifo: push while full");
            assert (!(pop && empty))
            else $error("tnoc_fifo: pop while empty");
        end
    end
`endif

endmodule

// File: rtl/tnoc_vc_input_buffer.sv
// Per-VC input buffering with registered upstream VC availability.
`timescale 1ns/1ps
module tnoc_vc_input_buffer
    import tnoc_pkg::*;
#(
    parameter tnoc_config    CONFIG          = TNOC_DEFAULT_CONFIG,
    parameter int            CHANNELS        = CONFIG.virtual_channels,
    parameter int            DEPTH           = 4,
    parameter int            THRESHOLD       = 2,
    parameter tnoc_port_type INPUT_PORT_TYPE = TNOC_INTERNAL_PORT
)(
    input  logic           clk,
    input  logic           rst_n,
    tnoc_flit_if.target    flit_in_if,
    tnoc_flit_if.initiator flit_out_if
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CHANNELS-1:0]        push;
    logic [CHANNELS-1:0]        pop;
    logic [CHANNELS-1:0]        full;
    logic [CHANNELS-1:0]        empty;
    logic [CHANNELS-1:0]        vca_d;
    logic [CHANNELS-1:0]        vca_q;
    logic [CNT_W-1:0]           count      [CHANNELS];
    logic [CNT_W-1:0]           next_count [CHANNELS];
    logic [TNOC_FLIT_WIDTH-1:0] push_data  [CHANNELS];
    logic [TNOC_FLIT_WIDTH-1:0] pop_data   [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_vc
        if (is_local_port(INPUT_PORT_TYPE)) begin : g_local
            assign push_data[i] = flit_in_if.flit[i];
        end else begin : g_internal
            assign push_data[i] = flit_in_if.flit[0];
        end

        // Ready comes from the count alone, so a full FIFO never accepts.
        assign push[i] = flit_in_if.valid[i] && !full[i];
        assign pop[i]  = !empty[i] && flit_out_if.ready[i];

        tnoc_fifo #(
            .WIDTH (TNOC_FLIT_WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[i]),
            .push_data (push_data[i]),
            .pop       (pop[i]),
            .pop_data  (pop_data[i]),
            .full      (full[i]),
            .empty     (empty[i]),
            .count     (count[i])
        );

        assign next_count[i] = count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        assign flit_out_if.flit[i] = tnoc_flit'(pop_data[i]);
    end

    always_comb begin
        vca_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            vca_d[i] = (DEPTH - int'(next_count[i])) >= THRESHOLD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vca_q <= '1;
        end else begin
            vca_q <= vca_d;
        end
    end

    assign flit_in_if.ready        = ~full;
    assign flit_in_if.vc_available = vca_q;
    assign flit_out_if.valid       = ~empty;

`ifndef SYNTHESIS
    logic [CHANNELS-1:0] hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= flit_out_if.valid & ~flit_out_if.ready;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert ((push & full) == '0)
            else $error("tnoc_vc_input_buffer: push to full VC");
            assert ((hold_q & ~flit_out_if.valid) == '0)
            else $error("tnoc_vc_input_buffer: valid dropped before pop");
            if (!is_local_port(INPUT_PORT_TYPE)) begin
                assert ($onehot0(flit_in_if.valid))
                else $error("tnoc_vc_input_buffer: multi-hot valid");
            end
        end
    end
`endif

endmodule

// File: tb/tb_tnoc_vc_input_buffer.sv
// Bench for tnoc_vc_input_buffer: 2 VCs, depth 4, threshold 2, internal input.
`timescale 1ns/1ps
module tb_tnoc_vc_input_buffer;
    import tnoc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tnoc_flit_if #(
        .CONFIG    (TNOC_DEFAULT_CONFIG),
        .PORT_TYPE (TNOC_INTERNAL_PORT)
    ) in_if ();

    tnoc_flit_if #(
        .CONFIG    (TNOC_DEFAULT_CONFIG),
        .PORT_TYPE (TNOC_LOCAL_PORT)
    ) out_if ();

    assign out_if.vc_available = '1;

    tnoc_vc_input_buffer #(
        .CONFIG          (TNOC_DEFAULT_CONFIG),
        .CHANNELS        (2),
        .DEPTH           (4),
        .THRESHOLD       (2),
        .INPUT_PORT_TYPE (TNOC_INTERNAL_PORT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flit_in_if  (in_if),
        .flit_out_if (out_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    tnoc_flit   sb [2][$];
    int         m_cnt [2];
    logic [1:0] m_vca;

    typedef struct {
        logic [1:0] vin;
        tnoc_flit   f;
        logic [1:0] ordy;
        logic [1:0] e_ready;
        logic [1:0] e_valid;
        logic [1:0] e_vca;
    } vec_t;

    vec_t tbl [11];

    function automatic tnoc_flit mk(tnoc_flit_type t, logic [31:0] d);
        tnoc_flit f;
        f.flit_type = t;
        f.head      = (t == TNOC_HEADER_FLIT);
        f.tail      = (t == TNOC_TAIL_FLIT);
        f.data      = d;
        return f;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            sb[i].delete();
            m_cnt[i] = 0;
        end
        m_vca = 2'b11;
    endtask

    // One clock: drive inputs, check heads, update the model, check after the edge.
    task automatic cycle(input logic [1:0] vin, input tnoc_flit f,
                         input logic [1:0] ordy);
        logic [1:0] m_ready;
        logic [1:0] m_valid;
        logic       do_push;
        logic       do_pop;
        in_if.valid   = vin;
        in_if.flit[0] = f;
        out_if.ready  = ordy;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (m_cnt[i] > 0) begin
                check($sformatf("head vc%0d", i), 64'(out_if.flit[i]),
                      64'(sb[i][0]));
            end
        end
        for (int i = 0; i < 2; i++) begin
            do_push = vin[i] && (m_cnt[i] < 4);
            do_pop  = ordy[i] && (m_cnt[i] > 0);
            if (do_pop) begin
                void'(sb[i].pop_front());
                m_cnt[i]--;
            end
            if (do_push) begin
                sb[i].push_back(f);
                m_cnt[i]++;
            end
            m_vca[i] = (4 - m_cnt[i]) >= 2;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            m_ready[i] = m_cnt[i] < 4;
            m_valid[i] = m_cnt[i] > 0;
        end
        check("ready", 64'(in_if.ready), 64'(m_ready));
        check("valid", 64'(out_if.valid), 64'(m_valid));
        check("vc_available", 64'(in_if.vc_available), 64'(m_vca));
    endtask

    initial begin
        in_if.valid   = '0;
        in_if.flit[0] = mk(TNOC_PAYLOAD_FLIT, 32'h0);
        out_if.ready  = '0;
        model_reset();

        tbl[0]  = '{2'b01, mk(TNOC_HEADER_FLIT,  32'hA0), 2'b00, 2'b11, 2'b01, 2'b11};
        tbl[1]  = '{2'b00, mk(TNOC_PAYLOAD_FLIT, 32'h00), 2'b01, 2'b11, 2'b00, 2'b11};
        tbl[2]  = '{2'b01, mk(TNOC_HEADER_FLIT,  32'h01), 2'b00, 2'b11, 2'b01, 2'b11};
        tbl[3]  = '{2'b01, mk(TNOC_PAYLOAD_FLIT, 32'h02), 2'b00, 2'b11, 2'b01, 2'b11};
        tbl[4]  = '{2'b01, mk(TNOC_PAYLOAD_FLIT, 32'h03), 2'b00, 2'b11, 2'b01, 2'b10};
        tbl[5]  = '{2'b01, mk(TNOC_PAYLOAD_FLIT, 32'h04), 2'b00, 2'b10, 2'b01, 2'b10};
        tbl[6]  = '{2'b01, mk(TNOC_TAIL_FLIT,    32'h05), 2'b01, 2'b11, 2'b01, 2'b10};
        tbl[7]  = '{2'b01, mk(TNOC_TAIL_FLIT,    32'h05), 2'b01, 2'b11, 2'b01, 2'b10};
        tbl[8]  = '{2'b00, mk(TNOC_PAYLOAD_FLIT, 32'h00), 2'b01, 2'b11, 2'b01, 2'b11};
        tbl[9]  = '{2'b00, mk(TNOC_PAYLOAD_FLIT, 32'h00), 2'b01, 2'b11, 2'b01, 2'b11};
        tbl[10] = '{2'b00, mk(TNOC_PAYLOAD_FLIT, 32'h00), 2'b01, 2'b11, 2'b00, 2'b11};

        // Power-on reset state.
        #12;
        check("rst valid", 64'(out_if.valid), 64'(2'b00));
        check("rst ready", 64'(in_if.ready), 64'(2'b11));
        check("rst vc_available", 64'(in_if.vc_available), 64'(2'b11));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset mid-traffic discards stored flits.
        cycle(2'b01, mk(TNOC_HEADER_FLIT,  32'h100), 2'b00);
        cycle(2'b01, mk(TNOC_PAYLOAD_FLIT, 32'h101), 2'b00);
        cycle(2'b10, mk(TNOC_HEADER_FLIT,  32'h200), 2'b00);
        cycle(2'b01, mk(TNOC_PAYLOAD_FLIT, 32'h102), 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst valid", 64'(out_if.valid), 64'(2'b00));
        check("midrst ready", 64'(in_if.ready), 64'(2'b11));
        check("midrst vc_available", 64'(in_if.vc_available), 64'(2'b11));
        in_if.valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cycle(2'b00, mk(TNOC_PAYLOAD_FLIT, 32'h0), 2'b11);
        cycle(2'b00, mk(TNOC_PAYLOAD_FLIT, 32'h0), 2'b11);

        // Single flit, fill to full, full with pop, ordered drain.
        for (int k = 0; k < 11; k++) begin
            cycle(tbl[k].vin, tbl[k].f, tbl[k].ordy);
            check($sformatf("tbl%0d ready", k), 64'(in_if.ready),
                  64'(tbl[k].e_ready));
            check($sformatf("tbl%0d valid", k), 64'(out_if.valid),
                  64'(tbl[k].e_valid));
            check($sformatf("tbl%0d vc_available", k),
                  64'(in_if.vc_available), 64'(tbl[k].e_vca));
        end

        // Interleaved packets: VC0 blocked downstream, VC1 drains.
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 3; k++) begin
                cycle((p == 0) ? 2'b01 : 2'b10,
                      mk((k == 0) ? TNOC_HEADER_FLIT :
                         (k == 2) ? TNOC_TAIL_FLIT : TNOC_PAYLOAD_FLIT,
                         32'h300 + 32'(p * 16 + k)),
                      2'b10);
            end
        end
        for (int k = 0; k < 3; k++) begin
            cycle(2'b00, mk(TNOC_PAYLOAD_FLIT, 32'h0), 2'b10);
        end
        check("il valid", 64'(out_if.valid), 64'(2'b01));
        check("il vc_available", 64'(in_if.vc_available), 64'(2'b10));
        for (int k = 0; k < 4; k++) begin
            cycle(2'b00, mk(TNOC_PAYLOAD_FLIT, 32'h0), 2'b11);
        end
        check("il drained", 64'(out_if.valid), 64'(2'b00));

        // Random push/pop on VC1 across pointer wrap.
        for (int k = 0; k < 20; k++) begin
            cycle({1'($urandom_range(0, 1)), 1'b0},
                  mk(TNOC_PAYLOAD_FLIT, 32'h400 + 32'(k)),
                  {1'($urandom_range(0, 1)), 1'b0});
        end
        for (int k = 0; k < 5; k++) begin
            cycle(2'b00, mk(TNOC_PAYLOAD_FLIT, 32'h0), 2'b11);
        end
        check("wrap drained", 64'(out_if.valid), 64'(2'b00));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
